// File: rtl/bip_pkg.sv
// Shared encodings for the BIP sequencer: opcodes, FSM states and
// accumulator mux selects.
package bip_pkg;

    localparam logic [4:0] OP_HALT = 5'd0;
    localparam logic [4:0] OP_STO  = 5'd1;
    localparam logic [4:0] OP_LD   = 5'd2;
    localparam logic [4:0] OP_LDI  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_SUBI = 5'd7;
    localparam logic [4:0] OP_BEQ  = 5'd8;
    localparam logic [4:0] OP_BNE  = 5'd9;
    localparam logic [4:0] OP_JMP  = 5'd10;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_A_RAM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;
    localparam logic [1:0] SEL_A_ACC = 2'b11;

endpackage

// File: rtl/bip_control_seq_if.sv
// Fetch and datapath-control bundle between the BIP sequencer and its
// surroundings; the sequencer connects through the slave modport.
interface bip_control_seq_if #(
    parameter int NB_DATA    = 16,
    parameter int NB_OPERAND = 11,
    parameter int NB_PC      = 11,
    parameter int NB_SEL_A   = 2,
    parameter int NB_ICNT    = 16
);
    logic                  i_valid;
    logic [NB_DATA-1:0]    i_instruction;
    logic                  i_acc_zero;
    logic [NB_PC-1:0]      o_addr_instr;
    logic [NB_OPERAND-1:0] o_data_addr;
    logic [NB_SEL_A-1:0]   o_sel_a;
    logic                  o_sel_b;
    logic                  o_op_code;
    logic                  o_wr_acc;
    logic                  o_wr_ram;
    logic                  o_rd_ram;
    logic                  o_halted;
    logic                  o_illegal;
    logic [NB_ICNT-1:0]    o_instr_count;

    modport master (
        output i_valid, i_instruction, i_acc_zero,
        input  o_addr_instr, o_data_addr, o_sel_a, o_sel_b, o_op_code,
               o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_illegal, o_instr_count
    );

    modport slave (
        input  i_valid, i_instruction, i_acc_zero,
        output o_addr_instr, o_data_addr, o_sel_a, o_sel_b, o_op_code,
               o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_illegal, o_instr_count
    );
endinterface

// File: rtl/bip_pc.sv
// Program counter: load has priority over increment; increment wraps
// naturally at the register width.
module bip_pc #(
    parameter int NB_PC = 11
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [NB_PC-1:0] i_target,
    output logic [NB_PC-1:0] o_pc
);
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pc <= '0;
        end else if (i_load) begin
            o_pc <= i_target;
        end else if (i_inc) begin
            o_pc <= o_pc + 1'b1;
        end
    end
endmodule

// File: rtl/bip_control_seq.sv
// BIP instruction sequencer: fetch/execute FSM, instruction register,
// RAM-latency wait timer and retired-instruction counter.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_FETCH | wait for i_valid, capture instruction into IR
//   ST_EXEC  | drive decoded controls; retire unless RAM read pending
//   ST_WAIT  | hold RAM-read controls until the latency timer expires
//   ST_HALT  | stopped by HALT or illegal opcode; only reset leaves
module bip_control_seq
    import bip_pkg::*;
#(
    parameter int NB_DATA     = 16,
    parameter int NB_OPCODE   = 5,
    parameter int NB_OPERAND  = 11,
    parameter int NB_PC       = 11,
    parameter int NB_SEL_A    = 2,
    parameter int RAM_LATENCY = 1,
    parameter int NB_ICNT     = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    bip_control_seq_if.slave bus
);
    localparam logic [1:0] WAIT_LOAD = 2'((RAM_LATENCY > 0) ? RAM_LATENCY - 1 : 0);

    state_t                state, state_nxt;
    logic [NB_DATA-1:0]    ir;
    logic [NB_ICNT-1:0]    instr_count;
    logic                  illegal;
    logic [1:0]            wait_cnt;
    logic [NB_OPCODE-1:0]  opcode;
    logic [NB_OPERAND-1:0] operand;
    logic [NB_SEL_A-1:0]   sel_a, ram_sel_a;
    logic                  sel_b, op_add, wr_acc, wr_ram, rd_ram;
    logic                  retire, set_illegal, wait_last;
    logic                  pc_load, pc_inc;
    logic [NB_PC-1:0]      pc;

    assign opcode    = ir[NB_DATA-1 -: NB_OPCODE];
    assign operand   = ir[NB_OPERAND-1:0];
    assign ram_sel_a = (opcode == OP_LD) ? SEL_A_RAM : SEL_A_ALU;
    assign wait_last = (wait_cnt == '0);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_FETCH;
            ir          <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH && bus.i_valid) ir <= bus.i_instruction;
            if (retire) instr_count <= instr_count + 1'b1;
            if (set_illegal) illegal <= 1'b1;
            if (state == ST_EXEC) begin
                wait_cnt <= WAIT_LOAD;
            end else if (!wait_last) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_a       = '0;
        sel_b       = 1'b0;
        op_add      = 1'b0;
        wr_acc      = 1'b0;
        wr_ram      = 1'b0;
        rd_ram      = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state)
            ST_FETCH: if (bus.i_valid) state_nxt = ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OP_HALT: state_nxt = ST_HALT;
                    OP_STO: begin
                        sel_a  = SEL_A_ACC;
                        wr_ram = 1'b1;
                        retire = 1'b1;
                    end
                    OP_LDI: begin
                        sel_a  = SEL_A_IMM;
                        wr_acc = 1'b1;
                        retire = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        sel_a  = SEL_A_ALU;
                        sel_b  = 1'b1;
                        op_add = (opcode == OP_ADDI);
                        wr_acc = 1'b1;
                        retire = 1'b1;
                    end
                    OP_LD, OP_ADD, OP_SUB: begin
                        sel_a  = ram_sel_a;
                        op_add = (opcode == OP_ADD);
                        rd_ram = 1'b1;
                        // Zero-latency RAM returns data in the same cycle, so write back now.
                        if (RAM_LATENCY == 0) begin
                            wr_acc = 1'b1;
                            retire = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                    OP_BEQ, OP_BNE, OP_JMP: retire = 1'b1;
                    default: begin
                        state_nxt   = ST_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
                if (retire) state_nxt = ST_FETCH;
            end
            ST_WAIT: begin
                sel_a  = ram_sel_a;
                op_add = (opcode == OP_ADD);
                rd_ram = 1'b1;
                if (wait_last) begin
                    wr_acc    = 1'b1;
                    retire    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            default: ;
        endcase
    end

    assign pc_load = retire && ((opcode == OP_JMP) ||
                                ((opcode == OP_BEQ) &&  bus.i_acc_zero) ||
                                ((opcode == OP_BNE) && !bus.i_acc_zero));
    assign pc_inc  = retire && !pc_load;

    bip_pc #(.NB_PC(NB_PC)) u_pc (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (pc_load),
        .i_inc     (pc_inc),
        .i_target  (operand[NB_PC-1:0]),
        .o_pc      (pc)
    );

    assign bus.o_addr_instr  = pc;
    assign bus.o_data_addr   = operand;
    assign bus.o_sel_a       = sel_a;
    assign bus.o_sel_b       = sel_b;
    assign bus.o_op_code     = op_add;
    assign bus.o_wr_acc      = wr_acc;
    assign bus.o_wr_ram      = wr_ram;
    assign bus.o_rd_ram      = rd_ram;
    assign bus.o_halted      = (state == ST_HALT);
    assign bus.o_illegal     = illegal;
    assign bus.o_instr_count = instr_count;
endmodule

// File: tb/tb_bip_control_seq.sv
// Bench for bip_control_seq: four parameter sets (RAM latency 1/3/0/2,
// PC width 11/11/11/4) driven in turn against an instruction-level model.
module tb_bip_control_seq;
    import bip_pkg::*;

    localparam int NCFG = 4;

    function automatic int lat_of(int c);
        case (c)
            0:       return 1;
            1:       return 3;
            2:       return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int nbpc_of(int c);
        return (c == 3) ? 4 : 11;
    endfunction

    logic i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    logic [NCFG-1:0]        rst_a, valid_a, az_a;
    logic [NCFG-1:0][15:0]  instr_a;
    logic [NCFG-1:0][10:0]  pc_a, daddr_a;
    logic [NCFG-1:0][6:0]   ctrl_a;
    logic [NCFG-1:0]        halted_a, illegal_a;
    logic [NCFG-1:0][15:0]  cnt_a;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int L   = lat_of(g);
        localparam int NPC = nbpc_of(g);

        bip_control_seq_if #(
            .NB_DATA(16), .NB_OPERAND(11), .NB_PC(NPC), .NB_SEL_A(2), .NB_ICNT(16)
        ) bus ();

        bip_control_seq #(
            .NB_DATA(16), .NB_OPCODE(5), .NB_OPERAND(11), .NB_PC(NPC),
            .NB_SEL_A(2), .RAM_LATENCY(L), .NB_ICNT(16)
        ) dut (
            .i_clock   (i_clock),
            .i_reset_n (rst_a[g]),
            .bus       (bus)
        );

        assign bus.i_valid       = valid_a[g];
        assign bus.i_instruction = instr_a[g];
        assign bus.i_acc_zero    = az_a[g];
        assign pc_a[g]      = 11'(bus.o_addr_instr);
        assign daddr_a[g]   = bus.o_data_addr;
        assign ctrl_a[g]    = {bus.o_sel_a, bus.o_sel_b, bus.o_op_code,
                               bus.o_wr_acc, bus.o_wr_ram, bus.o_rd_ram};
        assign halted_a[g]  = bus.o_halted;
        assign illegal_a[g] = bus.o_illegal;
        assign cnt_a[g]     = bus.o_instr_count;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int m_pc  [NCFG];
    int m_cnt [NCFG];

    task automatic check_val(input int c, input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL c%0d %s: got 0x%0h, expected 0x%0h", c, tag, act, exp);
        end
    endtask

    // Control vector {sel_a, sel_b, op_code, wr_acc, wr_ram, rd_ram} of one execute cycle.
    function automatic logic [6:0] exp_ctrl(input int op, input logic last);
        case (op)
            1:       return {2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            2:       return {2'b00, 1'b0, 1'b0, last, 1'b0, 1'b1};
            3:       return {2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            4:       return {2'b10, 1'b0, 1'b1, last, 1'b0, 1'b1};
            5:       return {2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            6:       return {2'b10, 1'b0, 1'b0, last, 1'b0, 1'b1};
            7:       return {2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            default: return 7'd0;
        endcase
    endfunction

    task automatic do_reset(input int c);
        rst_a[c]   = 1'b0;
        valid_a[c] = 1'b0;
        #1;
        check_val(c, "rst_pc", pc_a[c], 0);
        check_val(c, "rst_cnt", cnt_a[c], 0);
        check_val(c, "rst_ctrl", ctrl_a[c], 0);
        check_val(c, "rst_halted", halted_a[c], 0);
        check_val(c, "rst_illegal", illegal_a[c], 0);
        check_val(c, "rst_daddr", daddr_a[c], 0);
        @(negedge i_clock);
        rst_a[c] = 1'b1;
        m_pc[c]  = 0;
        m_cnt[c] = 0;
    endtask

    task automatic run_instr(input int c, input logic [15:0] ins, input logic az, input int stall);
        int op, opnd, n, mask, nxt;
        op   = int'(ins[15:11]);
        opnd = int'(ins[10:0]);
        mask = (1 << nbpc_of(c)) - 1;
        for (int s = 0; s < stall; s++) begin
            valid_a[c] = 1'b0;
            instr_a[c] = 16'($urandom);
            @(posedge i_clock);
            @(negedge i_clock);
            check_val(c, "stall_ctrl", ctrl_a[c], 0);
            check_val(c, "stall_pc", pc_a[c], m_pc[c]);
        end
        valid_a[c] = 1'b1;
        instr_a[c] = ins;
        az_a[c]    = az;
        @(posedge i_clock);
        #1;
        instr_a[c] = 16'($urandom);
        valid_a[c] = 1'($urandom);
        if (op == 0 || op > 10) begin
            @(negedge i_clock);
            check_val(c, "halt_exec_ctrl", ctrl_a[c], 0);
            @(posedge i_clock);
            @(negedge i_clock);
            check_val(c, "halt_flag", halted_a[c], 1);
            check_val(c, "halt_illegal", illegal_a[c], (op != 0) ? 1 : 0);
            check_val(c, "halt_pc", pc_a[c], m_pc[c]);
            check_val(c, "halt_cnt", cnt_a[c], m_cnt[c]);
        end else begin
            n = ((op == 2 || op == 4 || op == 6) && lat_of(c) > 0) ? lat_of(c) + 1 : 1;
            for (int k = 0; k < n; k++) begin
                if (k > 0) @(posedge i_clock);
                @(negedge i_clock);
                check_val(c, $sformatf("ctrl_op%0d_cyc%0d", op, k), ctrl_a[c], exp_ctrl(op, k == n - 1));
                check_val(c, "exec_daddr", daddr_a[c], opnd);
            end
            if (op == 10 || (op == 8 && az) || (op == 9 && !az)) nxt = opnd & mask;
            else nxt = (m_pc[c] + 1) & mask;
            m_pc[c]  = nxt;
            m_cnt[c] = (m_cnt[c] + 1) & 16'hFFFF;
            @(posedge i_clock);
            #1;
            az_a[c] = 1'($urandom);
            @(negedge i_clock);
            check_val(c, "retire_pc", pc_a[c], m_pc[c]);
            check_val(c, "retire_cnt", cnt_a[c], m_cnt[c]);
            check_val(c, "retire_halted", halted_a[c], 0);
            check_val(c, "fetch_ctrl", ctrl_a[c], 0);
        end
    endtask

    task automatic hold_halted(input int c, input int cycles);
        valid_a[c] = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            instr_a[c] = {OP_LDI, 11'($urandom)};
            @(posedge i_clock);
            @(negedge i_clock);
            check_val(c, "sticky_halted", halted_a[c], 1);
            check_val(c, "sticky_illegal", illegal_a[c], 1);
            check_val(c, "sticky_pc", pc_a[c], m_pc[c]);
            check_val(c, "sticky_ctrl", ctrl_a[c], 0);
        end
    endtask

    // Reset pulse landing inside the first wait cycle (or EXEC when latency is 0).
    task automatic abort_mid(input int c);
        int extra;
        extra      = (lat_of(c) > 0) ? 1 : 0;
        valid_a[c] = 1'b1;
        instr_a[c] = {OP_LD, 11'd9};
        @(posedge i_clock);
        for (int i = 0; i < extra; i++) @(posedge i_clock);
        #2;
        rst_a[c] = 1'b0;
        #1;
        check_val(c, "abort_ctrl", ctrl_a[c], 0);
        check_val(c, "abort_pc", pc_a[c], 0);
        check_val(c, "abort_cnt", cnt_a[c], 0);
        check_val(c, "abort_daddr", daddr_a[c], 0);
        check_val(c, "abort_halted", halted_a[c], 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clock);
            check_val(c, "abort_hold_ctrl", ctrl_a[c], 0);
        end
        valid_a[c] = 1'b0;
        rst_a[c]   = 1'b1;
        m_pc[c]    = 0;
        m_cnt[c]   = 0;
    endtask

    initial begin
        rst_a   = '0;
        valid_a = '0;
        az_a    = '0;
        instr_a = '0;
        @(negedge i_clock);
        for (int c = 0; c < NCFG; c++) begin
            do_reset(c);
            run_instr(c, {OP_LDI, 11'd5}, 1'b0, 0);
            run_instr(c, {OP_ADDI, 11'd3}, 1'b0, 0);
            run_instr(c, {OP_STO, 11'd7}, 1'b0, 0);
            run_instr(c, {OP_HALT, 11'd0}, 1'b0, 0);
            do_reset(c);
            run_instr(c, {OP_LD, 11'd4}, 1'b0, 1);
            for (int b = 0; b < 4; b++) begin
                run_instr(c, {OP_JMP, 11'd6}, 1'b0, 0);
                run_instr(c, {(b < 2) ? OP_BEQ : OP_BNE, 11'd20}, 1'(b % 2 == 0), 0);
            end
            run_instr(c, {OP_ADDI, 11'd1}, 1'b0, 5);
            run_instr(c, {OP_JMP, 11'd15}, 1'b0, 0);
            run_instr(c, {OP_ADDI, 11'd2}, 1'b0, 0);
            run_instr(c, {OP_ADD, 11'd33}, 1'b0, 0);
            run_instr(c, {OP_SUB, 11'd34}, 1'b0, 1);
            for (int r = 0; r < 40; r++) begin
                run_instr(c, {5'($urandom_range(1, 10)), 11'($urandom)}, 1'($urandom),
                          int'($urandom_range(0, 2)));
            end
            abort_mid(c);
            run_instr(c, {OP_LDI, 11'd1}, 1'b0, 0);
            run_instr(c, {5'd31, 11'h5}, 1'b0, 0);
            hold_halted(c, 10);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bip_control_seq.md
BIP_CONTROL_SEQ -- requirements
Module: bip_control_seq

Interface
REQ-001 Parameters: NB_DATA=16 instruction width; NB_OPCODE=5 opcode field width; NB_OPERAND=11 operand field width; NB_PC=11 program counter width; NB_SEL_A=2 accumulator mux select width; RAM_LATENCY=1 data-RAM read latency in cycles (legal 0..3); NB_ICNT=16 retired-instruction counter width.
REQ-002 i_clock  in  1  sole clock, rising edge.
REQ-003 i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_valid  in  1  fetch enable; FETCH advances only while high.
REQ-005 i_instruction  in  NB_DATA  instruction word read at o_addr_instr; opcode = [NB_DATA-1 -: NB_OPCODE]; operand = [NB_OPERAND-1:0].
REQ-006 i_acc_zero  in  1  accumulator-equals-zero flag from the datapath.
REQ-007 o_addr_instr  out  NB_PC  program counter.
REQ-008 o_data_addr  out  NB_OPERAND  operand field of the instruction register (IR).
REQ-009 o_sel_a  out  NB_SEL_A; o_sel_b  out  1; o_op_code  out  1 (1=add, 0=sub); o_wr_acc  out  1; o_wr_ram  out  1; o_rd_ram  out  1: datapath controls.
REQ-010 o_halted  out  1  FSM is in HALT; o_illegal  out  1  halt was caused by an undefined opcode.
REQ-011 o_instr_count  out  NB_ICNT  number of retired instructions.

Function
REQ-012 Opcodes: HALT=0, STO=1, LD=2, LDI=3, ADD=4, ADDI=5, SUB=6, SUBI=7, BEQ=8, BNE=9, JMP=10; every other value is illegal.
REQ-013 States: FETCH, EXEC, WAIT, HALT.
REQ-014 FETCH: when i_valid=1, IR <= i_instruction and next state is EXEC; when i_valid=0, remain in FETCH with all controls at 0.
REQ-015 EXEC, non-RAM-read instructions: assert the decoded controls for exactly one cycle, retire, PC update, then FETCH.
REQ-016 Control encodings: STO sel_a=11, wr_ram=1. LDI sel_a=01, wr_acc=1. ADD/SUB sel_a=10, sel_b=0, rd_ram=1, op_code=1/0. ADDI/SUBI sel_a=10, sel_b=1, wr_acc=1, op_code=1/0. LD sel_a=00, rd_ram=1. All unlisted controls are 0.
REQ-017 LD/ADD/SUB with RAM_LATENCY=0: EXEC also asserts wr_acc and the instruction retires in that cycle.
REQ-018 LD/ADD/SUB with RAM_LATENCY=L>0: EXEC asserts rd_ram with wr_acc=0, then WAIT holds rd_ram, sel_a, sel_b and op_code for L cycles; wr_acc=1 only in the last WAIT cycle, where the instruction retires and the FSM returns to FETCH.
REQ-019 Outside EXEC and WAIT, every control output is 0.
REQ-020 PC update on retire: JMP loads operand[NB_PC-1:0]; BEQ loads the operand if i_acc_zero=1, else PC+1; BNE loads the operand if i_acc_zero=0, else PC+1; all other instructions PC+1, wrapping from 2^NB_PC-1 to 0.
REQ-021 BEQ/BNE sample i_acc_zero in EXEC; branches take 2 cycles, taken or not.
REQ-022 HALT opcode: EXEC goes to HALT without retiring and leaves PC unchanged; o_halted=1. An illegal opcode does the same and also sets o_illegal=1.
REQ-023 HALT is sticky; only reset exits it, and i_valid is ignored while in HALT.
REQ-024 o_instr_count increments by 1 per retire and wraps modulo 2^NB_ICNT.
REQ-025 o_data_addr follows IR, not i_instruction, so it stays stable through WAIT.

Reset
REQ-026 i_reset_n low asynchronously sets state=FETCH, PC=0, IR=0, o_instr_count=0, o_illegal=0; all control outputs and o_halted are 0 while reset is held.
REQ-027 Reset asserted in EXEC or WAIT aborts the instruction: no retire, no PC update, and no further wr_acc or wr_ram pulse.
REQ-028 Operation resumes on the first rising edge after deassertion, with FETCH sampling i_valid.

Structure
REQ-029 Opcode localparams, state encodings and sel_a encodings live in a shared package, bip_pkg.
REQ-030 One sub-module, bip_pc: PC register with load, increment, wrap and asynchronous active-low reset; all other logic is inline.

Verification
REQ-031 Program LDI 5; ADDI 3; STO 7; HALT, RAM_LATENCY=1 -> wr_ram pulse with o_data_addr=7; HALT with o_addr_instr=3, o_instr_count=3, o_illegal=0.
REQ-032 LD 4 with RAM_LATENCY=3 -> rd_ram high for 4 consecutive cycles, wr_acc high only in the 4th; instruction takes 5 cycles from FETCH.
REQ-033 BEQ 20 at PC=6 with i_acc_zero=1 -> next PC=20; with i_acc_zero=0 -> next PC=7; BNE gives the inverse results.
REQ-034 i_valid held low for 5 cycles in FETCH -> PC and controls frozen; opcode 31 -> o_halted=1, o_illegal=1, and the FSM stays halted for 10 cycles with i_valid=1.
REQ-035 NB_PC=4, JMP 15 then ADDI -> PC 15 wraps to 0; i_reset_n pulsed low mid-WAIT -> immediate reset values and no wr_acc pulse.
